// File: rtl/wos_stream_feeder.sv
// wos_stream_feeder
//   DMA-style sequencer for the masked rank-order filter kernel. Reads len
//   samples from a synchronous sample RAM, streams them into the kernel one
//   per cycle with no bubbles, drops the N-1 warm-up results and writes each
//   full-window result to consecutive result RAM addresses.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   start               one-cycle request, ignored while busy
//   len, src_base,      job length, first sample address, first result
//   dst_base            address (all latched on an accepted start)
//   mask_cfg, rank_cfg  kernel configuration, latched on an accepted start
//   busy, done          status to the control register block
//   rd_en/rd_addr/rd_data   sample RAM port (read data one cycle late)
//   f_new/f_mask/f_rank     kernel inputs
//   f_out                   kernel result, FILT_LAT cycles after f_new
//   wr_en/wr_addr/wr_data   result RAM write port
module wos_stream_feeder #(
  parameter int N         = 7,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10,
  parameter int FILT_LAT  = 2,
  parameter int RANK_BITS = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] len,
  input  logic [ADDR_BITS-1:0] src_base,
  input  logic [ADDR_BITS-1:0] dst_base,
  input  logic [N-1:0]         mask_cfg,
  input  logic [RANK_BITS-1:0] rank_cfg,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic [DATA_BITS-1:0] f_new,
  output logic [N-1:0]         f_mask,
  output logic [RANK_BITS-1:0] f_rank,
  input  logic [DATA_BITS-1:0] f_out,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data
);

  // Read strobe to kernel result: 1 cycle RAM latency + 1 cycle f_new
  // register + FILT_LAT inside the kernel.
  localparam int PIPE = 2 + FILT_LAT;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] len_q;
  logic [ADDR_BITS-1:0] rd_cnt;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [PIPE-1:0]      vld_p;
  logic [PIPE-1:0]      tag_p;
  logic                 accept;
  logic                 last_rd;
  logic                 full_win;

  assign accept   = (state == IDLE) && start;
  assign last_rd  = (rd_cnt == len_q - ADDR_BITS'(1));
  // Only samples that complete a full window produce a result worth keeping.
  assign full_win = (rd_cnt >= ADDR_BITS'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (len == '0) ? FIN : READ;
      end
      READ: begin
        rd_en = 1'b1;
        if (last_rd) state_nxt = DRAIN;
      end
      // Leave only once every in-flight sample has left the tag pipe.
      DRAIN: if (vld_p == '0) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job configuration and read sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= '0;
      rd_cnt  <= '0;
      rd_addr <= '0;
      f_mask  <= '0;
      f_rank  <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (accept) begin
        len_q   <= len;
        rd_cnt  <= '0;
        rd_addr <= src_base;
        f_mask  <= mask_cfg;
        f_rank  <= rank_cfg;
      end else if (state == READ) begin
        rd_cnt  <= rd_cnt + ADDR_BITS'(1);
        rd_addr <= rd_addr + ADDR_BITS'(1);
      end
    end
  end

  // Stage p0: RAM data returning; stage p1: sample on f_new;
  // stage p(PIPE-1): kernel result for that sample on f_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
      tag_p <= '0;
      f_new <= '0;
    end else begin
      vld_p <= {vld_p[PIPE-2:0], rd_en};
      tag_p <= {tag_p[PIPE-2:0], rd_en && full_win};
      // Hold the last sample when nothing is arriving; the kernel keeps
      // shifting, but those results are untagged and dropped.
      if (vld_p[0]) f_new <= rd_data;
    end
  end

  // Writeback of tagged results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_ptr  <= '0;
    end else begin
      wr_en <= tag_p[PIPE-1];
      if (accept) begin
        wr_ptr <= dst_base;
      end else if (tag_p[PIPE-1]) begin
        wr_data <= f_out;
        wr_addr <= wr_ptr;
        wr_ptr  <= wr_ptr + ADDR_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_wos_stream_feeder.sv
// tb_wos_stream_feeder
//   Directed bench for wos_stream_feeder: a synchronous sample RAM model, a
//   behavioural masked rank-order kernel (latency 2), and a negedge monitor
//   logging reads, writes, done pulses and busy cycles.
module tb_wos_stream_feeder;

  localparam int N  = 7;
  localparam int DB = 8;
  localparam int AB = 10;
  localparam int RB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AB-1:0] len, src_base, dst_base;
  logic [N-1:0]  mask_cfg;
  logic [RB-1:0] rank_cfg;
  logic          busy, done, rd_en, wr_en;
  logic [AB-1:0] rd_addr, wr_addr;
  logic [DB-1:0] rd_data, f_new, f_out, wr_data;
  logic [N-1:0]  f_mask;
  logic [RB-1:0] f_rank;

  always #5 clk = ~clk;

  wos_stream_feeder #(.N(N), .DATA_BITS(DB), .ADDR_BITS(AB), .FILT_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .src_base(src_base),
    .dst_base(dst_base), .mask_cfg(mask_cfg), .rank_cfg(rank_cfg),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .f_new(f_new), .f_mask(f_mask), .f_rank(f_rank),
    .f_out(f_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Sample RAM, one-cycle read latency
  logic [DB-1:0] smem [1024];
  always @(posedge clk) if (rd_en) rd_data <= smem[rd_addr];

  // Kernel: 7-tap window, rank-th smallest (1-based) of masked taps
  function automatic logic [DB-1:0] kern(input logic [DB-1:0] w [N],
                                         input logic [N-1:0] m,
                                         input logic [RB-1:0] r);
    logic [DB-1:0] v [N];
    logic [DB-1:0] t;
    int n;
    n = 0;
    for (int i = 0; i < N; i++) v[i] = '0;
    for (int i = 0; i < N; i++) if (m[i]) begin v[n] = w[i]; n++; end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    if (r == 0 || int'(r) > n) return '0;
    return v[int'(r) - 1];
  endfunction

  logic [DB-1:0] win [N];
  logic [DB-1:0] kout;
  always @(posedge clk) begin
    for (int i = N - 1; i > 0; i--) win[i] <= win[i-1];
    win[0] <= f_new;
    kout   <= kern(win, f_mask, f_rank);
  end
  assign f_out = kout;

  // Monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nwr = 0, nrd = 0, ndone = 0, nbusy = 0, done_cyc = 0;
  logic [AB-1:0] wr_a [256];
  logic [DB-1:0] wr_d [256];
  int            wr_c [256];
  logic [AB-1:0] rd_a [256];

  always @(negedge clk) begin
    if (wr_en) begin
      wr_a[nwr % 256] = wr_addr;
      wr_d[nwr % 256] = wr_data;
      wr_c[nwr % 256] = cyc;
      nwr++;
    end
    if (rd_en) begin rd_a[nrd % 256] = rd_addr; nrd++; end
    if (done) begin ndone++; done_cyc = cyc; end
    if (busy) nbusy++;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_start(input logic [AB-1:0] l, input logic [AB-1:0] s,
                             input logic [AB-1:0] d, input logic [RB-1:0] r,
                             output int scyc);
    len = l; src_base = s; dst_base = d; mask_cfg = 7'h7F; rank_cfg = r;
    start = 1'b1;
    scyc = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int k;
    k = 0;
    while (ndone == d0 && k < 3000) begin tick(1); k++; end
    if (ndone == d0) check({tag, "_timeout"}, 32'd0, 32'd1);
    tick(10);
  endtask

  // Four writes of v0..v0+3 at dst.. on consecutive cycles
  task automatic check_seq(input string tag, input int w0, input logic [AB-1:0] dst,
                           input logic [DB-1:0] v0);
    logic [AB-1:0] a;
    check({tag, "_nwr"}, nwr - w0, 4);
    for (int i = 0; i < 4 && i < nwr - w0; i++) begin
      a = dst + AB'(i);
      check({tag, "_wdata"}, wr_d[(w0 + i) % 256], v0 + DB'(i));
      check({tag, "_waddr"}, wr_a[(w0 + i) % 256], a);
      if (i > 0) check({tag, "_wgap"}, wr_c[(w0 + i) % 256] - wr_c[(w0 + i - 1) % 256], 1);
    end
  endtask

  logic [AB-1:0] exp_ra [9] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002,
                                10'h003, 10'h004, 10'h005, 10'h006};
  logic [DB-1:0] wrap_s [9] = '{8'd50, 8'd10, 8'd40, 8'd20, 8'd60, 8'd30,
                                8'd70, 8'd80, 8'd90};

  initial begin
    int s, w0, r0, d0, b0, k;
    for (int i = 0; i < 1024; i++) smem[i] = '0;
    for (int i = 0; i < 10; i++) smem[16 + i] = DB'(i + 1);
    for (int i = 0; i < 9; i++) smem[exp_ra[i]] = wrap_s[i];
    rst = 1'b0; start = 1'b0; len = '0; src_base = '0; dst_base = '0;
    mask_cfg = '0; rank_cfg = '0;
    tick(3);

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_f_new", f_new, 0);
    check("rst_f_mask", f_mask, 0);
    check("rst_f_rank", f_rank, 0);
    check("rst_wr", {wr_en, wr_addr, wr_data}, 0);
    rst = 1'b1;
    tick(2);

    // Basic median run: samples 1..10 -> 4,5,6,7
    w0 = nwr; r0 = nrd; d0 = ndone;
    pulse_start(10'd10, 10'h010, 10'h100, 3'd4, s);
    check("t1_f_rank", f_rank, 4);
    check("t1_f_mask", f_mask, 7'h7F);
    wait_done(d0, "t1");
    check_seq("t1", w0, 10'h100, 8'd4);
    check("t1_nrd", nrd - r0, 10);
    check("t1_rd_first", rd_a[r0 % 256], 10'h010);
    check("t1_rd_last", rd_a[(r0 + 9) % 256], 10'h019);
    check("t1_ndone", ndone - d0, 1);
    check("t1_done_after_wr", done_cyc > wr_c[(w0 + 3) % 256], 1);

    // len = 0
    w0 = nwr; r0 = nrd; d0 = ndone; b0 = nbusy;
    pulse_start(10'd0, 10'h020, 10'h120, 3'd4, s);
    wait_done(d0, "len0");
    check("len0_nrd", nrd - r0, 0);
    check("len0_nwr", nwr - w0, 0);
    check("len0_ndone", ndone - d0, 1);
    check("len0_done_lat", done_cyc - s, 2);
    check("len0_busy_cycles", nbusy - b0, 1);

    // len < N
    w0 = nwr; r0 = nrd; d0 = ndone;
    pulse_start(10'd6, 10'h010, 10'h140, 3'd4, s);
    wait_done(d0, "len6");
    check("len6_nrd", nrd - r0, 6);
    check("len6_nwr", nwr - w0, 0);
    check("len6_ndone", ndone - d0, 1);

    // Address wrap on both sides
    w0 = nwr; r0 = nrd; d0 = ndone;
    pulse_start(10'd9, 10'h3FE, 10'h3FF, 3'd4, s);
    wait_done(d0, "wrap");
    check("wrap_nrd", nrd - r0, 9);
    for (int i = 0; i < 9; i++) check("wrap_rd_addr", rd_a[(r0 + i) % 256], exp_ra[i]);
    check("wrap_nwr", nwr - w0, 3);
    check("wrap_w0", {wr_a[w0 % 256], wr_d[w0 % 256]}, {10'h3FF, 8'd40});
    check("wrap_w1", {wr_a[(w0 + 1) % 256], wr_d[(w0 + 1) % 256]}, {10'h000, 8'd40});
    check("wrap_w2", {wr_a[(w0 + 2) % 256], wr_d[(w0 + 2) % 256]}, {10'h001, 8'd60});
    check("wrap_ndone", ndone - d0, 1);

    // Start while busy is ignored
    w0 = nwr; r0 = nrd; d0 = ndone;
    pulse_start(10'd10, 10'h010, 10'h200, 3'd4, s);
    tick(3);
    len = 10'd3; src_base = 10'h000; dst_base = 10'h050; rank_cfg = 3'd1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("busy_start_f_rank", f_rank, 4);
    wait_done(d0, "busy_start");
    check_seq("busy_start", w0, 10'h200, 8'd4);
    check("busy_start_nrd", nrd - r0, 10);
    check("busy_start_ndone", ndone - d0, 1);
    check("busy_start_f_rank_end", f_rank, 4);

    // Reset during the third write
    w0 = nwr; d0 = ndone;
    pulse_start(10'd10, 10'h010, 10'h300, 3'd4, s);
    k = 0;
    while (nwr - w0 < 3 && k < 100) begin tick(1); k++; end
    check("mid_rst_reach_w3", nwr - w0, 3);
    check("mid_rst_w3_live", wr_en, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_outs", {rd_en, rd_addr, f_new, f_rank, wr_addr, wr_data}, 0);
    tick(3);
    rst = 1'b1;
    tick(12);
    check("mid_rst_nwr", nwr - w0, 3);
    check("mid_rst_ndone", ndone - d0, 0);

    w0 = nwr; d0 = ndone;
    pulse_start(10'd10, 10'h010, 10'h080, 3'd4, s);
    wait_done(d0, "post_rst");
    check_seq("post_rst", w0, 10'h080, 8'd4);
    check("post_rst_ndone", ndone - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "global timeout");
  end

endmodule
